poly_sched: RTL and testbench

Round-robin scheduler that shares one `integer_polynomial` engine among `NREQ` requesters, such as the softmax i-exp lanes and the GELU lanes of the attention block. It does the following:
- accepts per-requester `(q, S)` operands;
- grants one requester at a time and latches its operands;
- issues a single start pulse to the engine and waits for its done;
- returns `q_out`/`S_out` to the granted requester.

It pre-screens `S == 0` as divide-by-zero and guards the engine with a watchdog. Coefficients `a`, `b` and `c` are wired from the parent directly to the engine and are static while `busy`.

---
 rtl/poly_sched_pkg.sv | 31 +++
 rtl/poly_sched_rr_arbiter.sv | 53 +++++
 rtl/poly_sched.sv | 214 +++++++++++++++++++++
 tb/tb_poly_sched.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_sched_pkg.sv
// -----------------------------------------------------------------------------
// poly_sched_pkg
// Shared definitions for the polynomial-engine scheduler:
//   sched_state_t : scheduler FSM states
//   DEF_Q_WIDTH / DEF_S_WIDTH : default operand widths
//   idx_w() / to_w() : widths of the requester index and watchdog counter
// -----------------------------------------------------------------------------
package poly_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_HALT  = 3'd4
    } sched_state_t;

    localparam int DEF_Q_WIDTH = 32;
    localparam int DEF_S_WIDTH = 16;

    // Index width for n requesters; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Counter width able to hold the value t (0..t inclusive).
    function automatic int to_w(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/poly_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: returns the first set request bit at or
// after ptr, wrapping modulo NREQ.
// Ports:
//   req   in  NREQ   : request vector
//   ptr   in  IDX_W  : highest-priority position (must be < NREQ)
//   found out 1      : at least one request is set
//   idx   out IDX_W  : chosen requester (0 when found is low)
// -----------------------------------------------------------------------------
module rr_arbiter
    import poly_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = idx_w(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Candidate k is (ptr + k) mod NREQ. Since ptr < NREQ the sum is below
    // 2*NREQ, so a single conditional subtraction implements the modulo.
    logic [IDX_W:0]   sum_w  [NREQ];
    logic [IDX_W:0]   wrap_w [NREQ];
    logic [IDX_W-1:0] cand   [NREQ];
    logic [NREQ-1:0]  hit;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            assign sum_w[gi]  = {1'b0, ptr} + (IDX_W+1)'(gi);
            assign wrap_w[gi] = sum_w[gi] - (IDX_W+1)'(NREQ);
            assign cand[gi]   = (sum_w[gi] >= (IDX_W+1)'(NREQ)) ?
                                wrap_w[gi][IDX_W-1:0] : sum_w[gi][IDX_W-1:0];
            assign hit[gi]    = req[cand[gi]];
        end
    endgenerate

    // Scan from the far end so the lowest rotated offset wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                found = 1'b1;
                idx   = cand[k];
            end
        end
    end

endmodule

// File: rtl/poly_sched.sv
// -----------------------------------------------------------------------------
// poly_sched
// Round-robin scheduler sharing one integer_polynomial engine among NREQ
// requesters. Grants one requester, latches its (q, S), starts the engine,
// waits for done under a watchdog and returns the result to that requester.
// S == 0 is answered directly as a divide-by-zero error without the engine.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req      in  NREQ          : level requests
//   req_q    in  NREQ*Q_WIDTH  : packed q operands (requester i at i*Q_WIDTH)
//   req_S    in  NREQ*S_WIDTH  : packed S operands
//   gnt      out NREQ          : one-hot, cycle the operands were captured
//   rsp_valid out NREQ         : one-hot result pulse
//   rsp_q / rsp_S / rsp_err    : result and divide-by-zero flag
//   busy     out 1             : scheduler not in IDLE
//   fault    out 1             : sticky watchdog fault
//   eng_start/eng_q/eng_S      : engine start pulse and latched operands
//   eng_done/eng_q_out/eng_S_out : engine completion and results
// All outputs are registered.
// -----------------------------------------------------------------------------
module poly_sched
    import poly_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int Q_WIDTH = DEF_Q_WIDTH,
    parameter int S_WIDTH = DEF_S_WIDTH,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*Q_WIDTH-1:0]   req_q,
    input  logic [NREQ*S_WIDTH-1:0]   req_S,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [Q_WIDTH-1:0]        rsp_q,
    output logic [S_WIDTH-1:0]        rsp_S,
    output logic                      rsp_err,
    output logic                      busy,
    output logic                      fault,
    output logic                      eng_start,
    output logic [Q_WIDTH-1:0]        eng_q,
    output logic [S_WIDTH-1:0]        eng_S,
    input  logic                      eng_done,
    input  logic [Q_WIDTH-1:0]        eng_q_out,
    input  logic [S_WIDTH-1:0]        eng_S_out
);

    localparam int IDX_W = idx_w(NREQ);
    localparam int TO_W  = to_w(TIMEOUT);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

    // Unpacked views of the operand buses.
    logic [Q_WIDTH-1:0] op_q [NREQ];
    logic [S_WIDTH-1:0] op_s [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign op_q[gi] = req_q[gi*Q_WIDTH +: Q_WIDTH];
            assign op_s[gi] = req_S[gi*S_WIDTH +: S_WIDTH];
        end
    endgenerate

    sched_state_t        state_reg, state_next;
    logic [IDX_W-1:0]    ptr_reg, ptr_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [TO_W-1:0]     cnt_reg, cnt_next;
    logic [NREQ-1:0]     gnt_reg, gnt_next;
    logic [NREQ-1:0]     rsp_valid_reg, rsp_valid_next;
    logic [Q_WIDTH-1:0]  rsp_q_reg, rsp_q_next;
    logic [S_WIDTH-1:0]  rsp_s_reg, rsp_s_next;
    logic                rsp_err_reg, rsp_err_next;
    logic                busy_reg, busy_next;
    logic                fault_reg, fault_next;
    logic                eng_start_reg, eng_start_next;
    logic [Q_WIDTH-1:0]  eng_q_reg, eng_q_next;
    logic [S_WIDTH-1:0]  eng_s_reg, eng_s_next;

    logic                arb_found;
    logic [IDX_W-1:0]    arb_idx;
    logic [Q_WIDTH-1:0]  sel_q;
    logic [S_WIDTH-1:0]  sel_s;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_reg),
        .found (arb_found),
        .idx   (arb_idx)
    );

    assign sel_q = op_q[arb_idx];
    assign sel_s = op_s[arb_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            ptr_reg       <= '0;
            idx_reg       <= '0;
            cnt_reg       <= '0;
            gnt_reg       <= '0;
            rsp_valid_reg <= '0;
            rsp_q_reg     <= '0;
            rsp_s_reg     <= '0;
            rsp_err_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            fault_reg     <= 1'b0;
            eng_start_reg <= 1'b0;
            eng_q_reg     <= '0;
            eng_s_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            idx_reg       <= idx_next;
            cnt_reg       <= cnt_next;
            gnt_reg       <= gnt_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_q_reg     <= rsp_q_next;
            rsp_s_reg     <= rsp_s_next;
            rsp_err_reg   <= rsp_err_next;
            busy_reg      <= busy_next;
            fault_reg     <= fault_next;
            eng_start_reg <= eng_start_next;
            eng_q_reg     <= eng_q_next;
            eng_s_reg     <= eng_s_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        idx_next       = idx_reg;
        cnt_next       = cnt_reg;
        rsp_q_next     = rsp_q_reg;
        rsp_s_next     = rsp_s_reg;
        rsp_err_next   = rsp_err_reg;
        fault_next     = fault_reg;
        eng_q_next     = eng_q_reg;
        eng_s_next     = eng_s_reg;
        // Pulse outputs fall back to zero every cycle.
        gnt_next       = '0;
        rsp_valid_next = '0;
        eng_start_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (arb_found && !fault_reg) begin
                    idx_next          = arb_idx;
                    eng_q_next        = sel_q;
                    eng_s_next        = sel_s;
                    gnt_next[arb_idx] = 1'b1;
                    // A zero divisor never reaches the engine.
                    eng_start_next    = (sel_s != '0);
                    state_next        = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (eng_s_reg == '0) begin
                    rsp_valid_next[idx_reg] = 1'b1;
                    rsp_err_next            = 1'b1;
                    rsp_q_next              = '0;
                    rsp_s_next              = '0;
                    state_next              = ST_RESP;
                end else begin
                    cnt_next   = '0;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Done is checked first so it wins a same-cycle timeout.
                if (eng_done) begin
                    rsp_valid_next[idx_reg] = 1'b1;
                    rsp_err_next            = 1'b0;
                    rsp_q_next              = eng_q_out;
                    rsp_s_next              = eng_S_out;
                    state_next              = ST_RESP;
                end else if (cnt_reg == TO_LIMIT) begin
                    fault_next = 1'b1;
                    state_next = ST_HALT;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_RESP: begin
                ptr_next   = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
                state_next = ST_IDLE;
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    assign gnt       = gnt_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_q     = rsp_q_reg;
    assign rsp_S     = rsp_s_reg;
    assign rsp_err   = rsp_err_reg;
    assign busy      = busy_reg;
    assign fault     = fault_reg;
    assign eng_start = eng_start_reg;
    assign eng_q     = eng_q_reg;
    assign eng_S     = eng_s_reg;

endmodule

// File: tb/tb_poly_sched.sv
// -----------------------------------------------------------------------------
// tb_poly_sched
// Scoreboard bench for poly_sched. A stimulus process drives requesters and,
// whenever a grant appears, pushes the round-robin winner and its expected
// response (from a simple engine function) into queues; a monitor pops and
// compares on every gnt / rsp_valid. A second instance with TIMEOUT = 8 is
// exercised directly for the done/timeout tie and the watchdog halt.
// -----------------------------------------------------------------------------
module tb_poly_sched;

    localparam int NREQ = 4;
    localparam int QW   = 32;
    localparam int SW   = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- main instance ----------------
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [QW-1:0]        op_q [NREQ];
    logic [SW-1:0]        op_s [NREQ];
    logic [NREQ*QW-1:0]   req_q;
    logic [NREQ*SW-1:0]   req_S;
    logic [NREQ-1:0]      gnt, rsp_valid;
    logic [QW-1:0]        rsp_q, eng_q, eng_q_out;
    logic [SW-1:0]        rsp_S, eng_S, eng_S_out;
    logic                 rsp_err, busy, fault, eng_start, eng_done;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_pack
            assign req_q[gi*QW +: QW] = op_q[gi];
            assign req_S[gi*SW +: SW] = op_s[gi];
        end
    endgenerate

    poly_sched #(.NREQ(NREQ), .Q_WIDTH(QW), .S_WIDTH(SW), .TIMEOUT(255)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_q(req_q), .req_S(req_S),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_q(rsp_q), .rsp_S(rsp_S),
        .rsp_err(rsp_err), .busy(busy), .fault(fault), .eng_start(eng_start),
        .eng_q(eng_q), .eng_S(eng_S), .eng_done(eng_done),
        .eng_q_out(eng_q_out), .eng_S_out(eng_S_out)
    );

    // ---------------- watchdog instance ----------------
    logic                 wd_rst_n;
    logic [NREQ-1:0]      wd_req, wd_gnt, wd_rsp_valid;
    logic [NREQ*QW-1:0]   wd_req_q;
    logic [NREQ*SW-1:0]   wd_req_S;
    logic [QW-1:0]        wd_rsp_q, wd_eng_q, wd_eng_q_out;
    logic [SW-1:0]        wd_rsp_S, wd_eng_S, wd_eng_S_out;
    logic                 wd_rsp_err, wd_busy, wd_fault, wd_eng_start, wd_eng_done;

    poly_sched #(.NREQ(NREQ), .Q_WIDTH(QW), .S_WIDTH(SW), .TIMEOUT(8)) u_wd (
        .clk(clk), .rst_n(wd_rst_n), .req(wd_req), .req_q(wd_req_q), .req_S(wd_req_S),
        .gnt(wd_gnt), .rsp_valid(wd_rsp_valid), .rsp_q(wd_rsp_q), .rsp_S(wd_rsp_S),
        .rsp_err(wd_rsp_err), .busy(wd_busy), .fault(wd_fault), .eng_start(wd_eng_start),
        .eng_q(wd_eng_q), .eng_S(wd_eng_S), .eng_done(wd_eng_done),
        .eng_q_out(wd_eng_q_out), .eng_S_out(wd_eng_S_out)
    );

    // ---------------- reference model ----------------
    function automatic logic [QW-1:0] fq(input logic [QW-1:0] q);
        return q * 32'd6;
    endfunction

    function automatic logic [SW-1:0] fs(input logic [SW-1:0] s);
        return (s >> 8) + 16'd6;
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    typedef struct { int idx; logic [QW-1:0] q; logic [SW-1:0] s; } gexp_t;
    typedef struct { int idx; logic err; logic [QW-1:0] q; logic [SW-1:0] s; } rexp_t;
    gexp_t gq[$];
    rexp_t rq[$];

    logic [NREQ-1:0] auto_mask = '0;
    bit   rand_mode = 1'b0;
    bit   spur_en   = 1'b0;
    int   fixed_lat = 0;
    int   ptr_m     = 0;
    int   gnt_count = 0;
    int   done_cyc  = 0;
    int   last_gnt_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic new_op(input int i);
        op_q[i] = $urandom;
        op_s[i] = ($urandom_range(7) == 0) ? 16'd0 : 16'($urandom);
    endtask

    // One clock of requester behaviour, executed just after the rising edge.
    task automatic step();
        int    w;
        gexp_t g;
        rexp_t r;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            ptr_m = 0;
        end else begin
            if (gnt != '0) begin
                w = rr_pick(req, ptr_m);
                if (w >= 0) begin
                    g.idx = w; g.q = op_q[w]; g.s = op_s[w];
                    r.idx = w;
                    r.err = (op_s[w] == '0);
                    r.q   = r.err ? '0 : fq(op_q[w]);
                    r.s   = r.err ? '0 : fs(op_s[w]);
                    gq.push_back(g);
                    rq.push_back(r);
                    ptr_m = (w + 1) % NREQ;
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (gnt[i]) begin
                        if (auto_mask[i]) new_op(i);
                        else req[i] = 1'b0;
                    end
                end
            end
            if (rand_mode) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!req[i] && $urandom_range(3) == 0) begin
                        new_op(i);
                        req[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (n < 800 && (req != '0 || gq.size() != 0 || rq.size() != 0 || busy)) begin
            step();
            n++;
        end
        checks++;
        if (n >= 800) begin
            errors++;
            $display("FAIL drain actual=busy_after_%0d_cycles required=idle", n);
        end
    endtask

    task automatic check_zero(input string name);
        check(name, 64'({|eng_q, |eng_S, |rsp_q, |rsp_S, gnt, rsp_valid,
                         busy, fault, eng_start, rsp_err}), 64'd0);
    endtask

    // ---------------- engine model ----------------
    initial begin : engine
        int            cnt;
        logic [QW-1:0] lq;
        logic [SW-1:0] ls;
        cnt = 0; lq = '0; ls = '0;
        eng_done = 1'b0; eng_q_out = '0; eng_S_out = '0;
        forever begin
            @(negedge clk);
            eng_done = 1'b0;
            if (!rst_n) begin
                cnt = 0;
            end else if (eng_start) begin
                lq  = eng_q;
                ls  = eng_S;
                cnt = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(20, 1));
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    eng_done  = 1'b1;
                    eng_q_out = fq(lq);
                    eng_S_out = fs(ls);
                    done_cyc  = cyc;
                end
            end else if (spur_en && $urandom_range(15) == 0) begin
                // Stray done pulses outside WAIT must be ignored.
                eng_done  = 1'b1;
                eng_q_out = $urandom;
                eng_S_out = 16'($urandom);
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        gexp_t g;
        rexp_t r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                gq.delete();
                rq.delete();
            end else begin
                if (gnt != '0) begin
                    gnt_count++;
                    last_gnt_cyc = cyc;
                    if (gq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL gnt_unexpected actual=%b required=none", gnt);
                    end else begin
                        g = gq.pop_front();
                        $display("grant cyc=%0d req=%0d q=%0h S=%0h", cyc, g.idx, g.q, g.s);
                        check("gnt", 64'(gnt), 64'(1 << g.idx));
                        check("eng_start", 64'(eng_start), 64'(g.s != '0));
                        if (g.s != '0) begin
                            check("eng_q", 64'(eng_q), 64'(g.q));
                            check("eng_S", 64'(eng_S), 64'(g.s));
                        end
                    end
                end
                if (rsp_valid != '0) begin
                    if (rq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rsp_unexpected actual=%b required=none", rsp_valid);
                    end else begin
                        r = rq.pop_front();
                        $display("resp  cyc=%0d req=%0d q=%0h S=%0h err=%0d",
                                 cyc, r.idx, rsp_q, rsp_S, rsp_err);
                        check("rsp_valid", 64'(rsp_valid), 64'(1 << r.idx));
                        check("rsp_err", 64'(rsp_err), 64'(r.err));
                        check("rsp_q", 64'(rsp_q), 64'(r.q));
                        check("rsp_S", 64'(rsp_S), 64'(r.s));
                        check("rsp_cycle", 64'(cyc),
                              64'(r.err ? last_gnt_cyc + 1 : done_cyc + 1));
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int base;
        int n;
        rst_n = 1'b0; wd_rst_n = 1'b0;
        req = '0;
        for (int i = 0; i < NREQ; i++) begin op_q[i] = '0; op_s[i] = '0; end
        wd_req = '0; wd_req_q = '0; wd_req_S = '0;
        wd_eng_done = 1'b0; wd_eng_q_out = '0; wd_eng_S_out = '0;

        repeat (3) step();
        @(negedge clk);
        check_zero("reset_outputs");
        rst_n = 1'b1; wd_rst_n = 1'b1;

        // Single requester, 40-cycle engine.
        step();
        fixed_lat = 40;
        op_q[0] = 32'd5; op_s[0] = 16'h0100; req = 4'b0001;
        step();
        @(negedge clk);
        check("single_gnt", 64'(gnt), 64'b0001);
        check("single_start", 64'(eng_start), 64'd1);
        check("single_eng_q", 64'(eng_q), 64'd5);
        repeat (41) step();
        @(negedge clk);
        check("single_rsp_valid", 64'(rsp_valid), 64'b0001);
        check("single_rsp_q", 64'(rsp_q), 64'd30);
        check("single_rsp_S", 64'(rsp_S), 64'd7);
        check("single_rsp_err", 64'(rsp_err), 64'd0);
        drain();

        // Fairness with every requester held high.
        fixed_lat = 0;
        step();
        auto_mask = 4'b1111;
        for (int i = 0; i < NREQ; i++) new_op(i);
        req = 4'b1111;
        base = gnt_count;
        n = 0;
        while (gnt_count < base + 12 && n < 1000) begin step(); n++; end
        check("fair_grant_budget", 64'(n < 1000), 64'd1);
        auto_mask = '0;
        drain();

        // Divide by zero on requester 2.
        step();
        op_q[2] = $urandom; op_s[2] = 16'd0; req = 4'b0100;
        step();
        @(negedge clk);
        check("dz_gnt", 64'(gnt), 64'b0100);
        check("dz_start", 64'(eng_start), 64'd0);
        step();
        @(negedge clk);
        check("dz_rsp_valid", 64'(rsp_valid), 64'b0100);
        check("dz_rsp_err", 64'(rsp_err), 64'd1);
        check("dz_rsp_data", 64'({rsp_q, rsp_S}), 64'd0);
        drain();

        // Random traffic with stray done pulses.
        rand_mode = 1'b1; spur_en = 1'b1;
        repeat (3000) step();
        rand_mode = 1'b0; spur_en = 1'b0;
        drain();

        // Reset while waiting on the engine, requester 1 held.
        fixed_lat = 40;
        step();
        auto_mask = 4'b0010;
        op_q[1] = $urandom; op_s[1] = 16'h0042; req = 4'b0010;
        repeat (6) step();
        @(negedge clk);
        check("rst_pre_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid_outputs");
        repeat (2) step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        check("rst_fresh_gnt", 64'(gnt), 64'b0010);
        auto_mask = '0;
        drain();

        // Done arriving exactly in the timeout cycle (TIMEOUT = 8).
        step();
        wd_req = 4'b0001; wd_req_q = 128'd7; wd_req_S = 64'd3;
        step();
        @(negedge clk);
        check("tie_gnt", 64'(wd_gnt), 64'b0001);
        wd_req = '0;
        repeat (9) step();
        wd_eng_done = 1'b1; wd_eng_q_out = 32'h1234_5678; wd_eng_S_out = 16'hbeef;
        step();
        wd_eng_done = 1'b0;
        @(negedge clk);
        check("tie_rsp_valid", 64'(wd_rsp_valid), 64'b0001);
        check("tie_rsp_q", 64'(wd_rsp_q), 64'h1234_5678);
        check("tie_rsp_S", 64'(wd_rsp_S), 64'hbeef);
        check("tie_rsp_err", 64'(wd_rsp_err), 64'd0);
        check("tie_fault", 64'(wd_fault), 64'd0);
        step();
        @(negedge clk);
        check("tie_idle", 64'({wd_fault, wd_busy}), 64'd0);

        // Watchdog: engine never answers.
        step();
        wd_req = 4'b0001; wd_req_S = 64'd5;
        step();
        @(negedge clk);
        check("wd_gnt", 64'(wd_gnt), 64'b0001);
        for (int c = 2; c <= 11; c++) begin
            step();
            @(negedge clk);
            check($sformatf("wd_fault_c%0d", c), 64'(wd_fault), 64'(c == 11));
        end
        for (int c = 0; c < 6; c++) begin
            step();
            @(negedge clk);
            check("wd_halt", 64'({wd_gnt, wd_eng_start, wd_busy, wd_fault}), 64'b0000_0_1_1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : global_timeout
        #600000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
